// File: rtl/patch_scheduler_if.sv
// Patch scheduler handshake bundle: frame control, patch-cache fetch,
// patchifier control and the downstream vectorized-patch handshake.
interface patch_scheduler_if #(
  parameter int GRID_W = 4,
  parameter int GRID_H = 4
);
  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int IW = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1;

  logic          start;
  logic          abort;
  logic          fetch_req;
  logic [RW-1:0] fetch_row;
  logic [CW-1:0] fetch_col;
  logic          fetch_ack;
  logic          pf_en;
  logic [1:0]    pf_state;
  logic          pf_output_taken;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_patch_idx;
  logic          busy;
  logic          frame_done;
  logic          error;

  // scheduler side
  modport slave (
    input  start, abort, fetch_ack, pf_state, out_ready,
    output fetch_req, fetch_row, fetch_col, pf_en, pf_output_taken,
           out_valid, out_patch_idx, busy, frame_done, error
  );

  // controller / environment side
  modport master (
    output start, abort, fetch_ack, pf_state, out_ready,
    input  fetch_req, fetch_row, fetch_col, pf_en, pf_output_taken,
           out_valid, out_patch_idx, busy, frame_done, error
  );
endinterface

// File: rtl/patch_scheduler.sv
// Walks a GRID_H x GRID_W patch grid in raster order: fetch each patch into
// the cache, launch the patchifier, wait for it, then hand the result
// downstream. Illegal patchifier state or a WAIT timeout flags a sticky error.
module patch_scheduler #(
  parameter int GRID_W  = 4,
  parameter int GRID_H  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  patch_scheduler_if.slave bus
);
  localparam int RW   = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int CW   = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int IW   = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_DRAIN
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   row, row_n;
  logic [CW-1:0]   col, col_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            err, err_n;
  logic            done, done_n;
  logic            hs, last_patch, pf_illegal, pf_idle, pf_done;

  assign pf_idle    = (bus.pf_state == 2'b00);
  assign pf_done    = (bus.pf_state == 2'b10);
  assign pf_illegal = (bus.pf_state == 2'b11);
  assign hs         = (state == S_DRAIN) && bus.out_ready;
  assign last_patch = (row == RW'(GRID_H - 1)) && (col == CW'(GRID_W - 1));

  // state, position, wait counter and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      cnt   <= cnt_n;
      err   <= err_n;
      done  <= done_n;
    end
  end

  // next-state: abort beats everything, then illegal patchifier state
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    cnt_n   = cnt;
    err_n   = err;
    done_n  = 1'b0;
    if (bus.abort) begin
      state_n = S_IDLE;
    end else if (state != S_IDLE && pf_illegal) begin
      err_n   = 1'b1;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          row_n   = '0;
          col_n   = '0;
          err_n   = 1'b0;
          state_n = S_FETCH;
        end
        S_FETCH: if (bus.fetch_ack) state_n = S_LAUNCH;
        S_LAUNCH: if (pf_idle) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          cnt_n = cnt + 1'b1;
          // done wins over a timeout landing in the same cycle
          if (pf_done) state_n = S_DRAIN;
          else if (cnt == CNTW'(TIMEOUT - 1)) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_DRAIN: if (bus.out_ready) begin
          if (last_patch) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_FETCH;
            if (col == CW'(GRID_W - 1)) begin
              col_n = '0;
              row_n = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (state != S_IDLE);
  assign bus.fetch_req     = (state == S_FETCH);
  assign bus.fetch_row     = row;
  assign bus.fetch_col     = col;
  // no launch into a frame that is being cancelled this cycle
  assign bus.pf_en         = (state == S_LAUNCH) && pf_idle && !bus.abort;
  assign bus.out_valid     = (state == S_DRAIN);
  assign bus.out_patch_idx = IW'(row) * IW'(GRID_W) + IW'(col);
  // an abort still releases a finished patchifier result so it is not left hanging
  assign bus.pf_output_taken = hs || (bus.abort && (state != S_IDLE) && pf_done);
  assign bus.error         = err;
  assign bus.frame_done    = done;
endmodule

// File: tb/tb_patch_scheduler.sv
// Bench for patch_scheduler: 2x2 grid, behavioural patchifier and cache,
// a raster-order reference (patch k of a frame must be index k) and a second
// instance with a short timeout for the stuck-patchifier case.
module tb_patch_scheduler;
  localparam int GW = 2, GH = 2, NP = GW * GH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  patch_scheduler_if #(.GRID_W(GW), .GRID_H(GH)) ifc ();
  patch_scheduler_if #(.GRID_W(GW), .GRID_H(GH)) ifc2 ();

  patch_scheduler #(.GRID_W(GW), .GRID_H(GH), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );
  patch_scheduler #(.GRID_W(GW), .GRID_H(GH), .TIMEOUT(20)) dut_to (
    .clk(clk), .reset(reset), .bus(ifc2.slave)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- patchifier and patch-cache models ----
  int         pf_lat = 1;
  bit         pf_force = 1'b0;
  logic [1:0] pf_fval = 2'b00;
  bit         ack_rand = 1'b0;
  logic [1:0] m_st;
  int         m_cnt;

  assign ifc.pf_state = pf_force ? pf_fval : m_st;

  // patchifier: IDLE -> PROCESSING for pf_lat cycles -> DONE until taken; cache ack after >=1 cycle
  always @(posedge clk) begin
    if (reset) begin
      m_st          <= 2'b00;
      m_cnt         <= 0;
      ifc.fetch_ack <= 1'b0;
    end else begin
      ifc.fetch_ack <= ifc.fetch_req && !ifc.fetch_ack && (!ack_rand || ($urandom_range(0, 2) == 0));
      case (m_st)
        2'b00: if (ifc.pf_en) begin m_st <= 2'b01; m_cnt <= pf_lat; end
        2'b01: if (m_cnt <= 1) m_st <= 2'b10; else m_cnt <= m_cnt - 1;
        2'b10: if (ifc.pf_output_taken) m_st <= 2'b00;
        default: m_st <= 2'b00;
      endcase
    end
  end

  // ---- monitor: per-cycle rules and event logs ----
  bit         mon_en = 1'b0;
  int         en_cnt = 0, tk_cnt = 0, done_cnt = 0;
  int         hs_q[$], fe_q[$];
  bit         prev_stall = 1'b0;
  logic [1:0] prev_idx = '0;

  // sample away from the active edge
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("exclusive_req_en_valid", ($countones({ifc.fetch_req, ifc.pf_en, ifc.out_valid}) <= 1), 1);
      chk("taken_rule", ifc.pf_output_taken,
          (ifc.out_valid & ifc.out_ready) | (ifc.abort & (ifc.pf_state == 2'b10)));
      if (prev_stall) begin
        chk("stall_valid_held", ifc.out_valid, 1);
        chk("stall_idx_held", ifc.out_patch_idx, prev_idx);
      end
      if (ifc.frame_done) chk("done_in_idle", ifc.busy, 0);
      prev_stall <= ifc.out_valid && !ifc.out_ready && !ifc.abort;
      prev_idx   <= ifc.out_patch_idx;
      if (ifc.pf_en) en_cnt <= en_cnt + 1;
      if (ifc.pf_output_taken) tk_cnt <= tk_cnt + 1;
      if (ifc.frame_done) done_cnt <= done_cnt + 1;
      if (ifc.out_valid && ifc.out_ready && !ifc.abort) hs_q.push_back(int'(ifc.out_patch_idx));
      if (ifc.fetch_req && ifc.fetch_ack && !ifc.abort)
        fe_q.push_back(int'(ifc.fetch_row) * GW + int'(ifc.fetch_col));
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // ---- helpers ----
  int en_b, tk_b, dn_b, hs_b, fe_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return ifc.fetch_req;
      1:       return ifc.pf_en;
      default: return ifc.out_valid;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (sig(which)) begin ok = 1'b1; break; end
      step();
    end
    chk(tag, ok, 1);
  endtask

  task automatic start_frame(input int lat);
    pf_lat = lat;
    en_b = en_cnt; tk_b = tk_cnt; dn_b = done_cnt; hs_b = hs_q.size(); fe_b = fe_q.size();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    chk("start_busy", ifc.busy, 1);
    chk("start_fetch_req", ifc.fetch_req, 1);
  endtask

  task automatic finish_frame(input bit rnd);
    int c = 0;
    while (done_cnt == dn_b && c < 6000) begin
      ifc.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      c++;
    end
    ifc.out_ready = 1'b0;
    step();
    step();
    chk("frame_done_seen", (done_cnt != dn_b), 1);
  endtask

  // reference: one fetch, launch, release and handoff per patch, indices 0..NP-1
  task automatic check_frame();
    chk("handoff_count", hs_q.size() - hs_b, NP);
    chk("fetch_count", fe_q.size() - fe_b, NP);
    for (int i = 0; i < NP; i++) begin
      if (hs_b + i < hs_q.size()) chk("handoff_idx", hs_q[hs_b + i], i);
      if (fe_b + i < fe_q.size()) chk("fetch_coord", fe_q[fe_b + i], i);
    end
    chk("pf_en_pulses", en_cnt - en_b, NP);
    chk("taken_pulses", tk_cnt - tk_b, NP);
    chk("frame_done_pulses", done_cnt - dn_b, 1);
    chk("idle_after_frame", ifc.busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_error"}, ifc.error, 0);
    chk({tag, "_frame_done"}, ifc.frame_done, 0);
    chk({tag, "_fetch_req"}, ifc.fetch_req, 0);
    chk({tag, "_pf_en"}, ifc.pf_en, 0);
    chk({tag, "_taken"}, ifc.pf_output_taken, 0);
    chk({tag, "_out_valid"}, ifc.out_valid, 0);
    chk({tag, "_idx"}, ifc.out_patch_idx, 0);
    chk({tag, "_fetch_row"}, ifc.fetch_row, 0);
    chk({tag, "_fetch_col"}, ifc.fetch_col, 0);
  endtask

  // ---- directed sequence ----
  initial begin
    int dn;
    bit ok, seen_done;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.out_ready = 1'b0;
    ifc2.start = 1'b0; ifc2.abort = 1'b0; ifc2.fetch_ack = 1'b1;
    ifc2.out_ready = 1'b1; ifc2.pf_state = 2'b00;
    repeat (3) step();
    reset = 1'b0;
    check_zero_outputs("reset");
    mon_en = 1'b1;

    // nominal frame, 258-cycle patchifier, ready always high
    ack_rand = 1'b0;
    start_frame(258);
    finish_frame(1'b0);
    check_frame();

    // downstream holds ready low for 5 cycles on the first patch
    ifc.out_ready = 1'b0;
    start_frame(5);
    wait_sig("wait_valid_stall", 2, 200);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", ifc.out_valid, 1);
      chk("stall_idx", ifc.out_patch_idx, 0);
      chk("stall_no_taken", ifc.pf_output_taken, 0);
      if (i < 4) step();
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("ready_taken", ifc.pf_output_taken, 1);
    finish_frame(1'b0);
    check_frame();

    // patchifier not idle for several LAUNCH cycles, start pulsed while busy
    start_frame(10);
    pf_force = 1'b1;
    pf_fval  = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!ifc.fetch_req) begin ok = 1'b1; break; end
    end
    chk("launch_reached", ok, 1);
    for (int i = 0; i < 3; i++) begin
      chk("launch_hold_no_en", ifc.pf_en, 0);
      chk("launch_hold_busy", ifc.busy, 1);
      ifc.start = (i == 1);
      step();
    end
    ifc.start = 1'b0;
    pf_force  = 1'b0;
    #1;
    chk("launch_go_en", ifc.pf_en, 1);
    finish_frame(1'b0);
    check_frame();

    // randomized frames: latency, cache ack delay and downstream ready
    for (int f = 0; f < 6; f++) begin
      ack_rand = 1'b1;
      start_frame(int'($urandom_range(1, 40)));
      finish_frame(1'b1);
      check_frame();
    end
    ack_rand = 1'b0;

    // abort in WAIT while patchifier reports DONE
    start_frame(50);
    wait_sig("wait_pf_en", 1, 20);
    step();
    pf_force = 1'b1;
    pf_fval  = 2'b10;
    ifc.abort = 1'b1;
    #1;
    chk("abort_wait_taken", ifc.pf_output_taken, 1);
    chk("abort_wait_no_valid", ifc.out_valid, 0);
    dn = done_cnt;
    step();
    ifc.abort = 1'b0;
    pf_force  = 1'b0;
    chk("abort_wait_idle", ifc.busy, 0);
    chk("abort_wait_err", ifc.error, 0);
    step();
    step();
    chk("abort_wait_no_done", done_cnt - dn, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // illegal patchifier state mid-frame, error sticky until next start
    start_frame(8);
    pf_force = 1'b1;
    pf_fval  = 2'b11;
    dn = done_cnt;
    step();
    pf_force = 1'b0;
    chk("illegal_err", ifc.error, 1);
    chk("illegal_idle", ifc.busy, 0);
    step();
    step();
    chk("illegal_err_sticky", ifc.error, 1);
    chk("illegal_no_done", done_cnt - dn, 0);
    start_frame(8);
    chk("illegal_err_cleared", ifc.error, 0);
    finish_frame(1'b0);
    check_frame();

    // abort coinciding with a DRAIN handshake
    ifc.out_ready = 1'b0;
    start_frame(4);
    wait_sig("wait_valid_abort", 2, 100);
    ifc.out_ready = 1'b1;
    ifc.abort = 1'b1;
    #1;
    chk("abort_hs_taken", ifc.pf_output_taken, 1);
    dn = done_cnt;
    step();
    ifc.abort = 1'b0;
    ifc.out_ready = 1'b0;
    chk("abort_hs_idle", ifc.busy, 0);
    step();
    chk("abort_hs_no_done", done_cnt - dn, 0);
    start_frame(4);
    finish_frame(1'b0);
    check_frame();

    // abort wins over start in IDLE
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    step();
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    chk("abort_beats_start", ifc.busy, 0);

    // reset in the middle of DRAIN, then a clean restart from patch 0
    ifc.out_ready = 1'b0;
    start_frame(6);
    wait_sig("wait_valid_reset", 2, 100);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero_outputs("mid_reset");
    start_frame(6);
    chk("restart_row", ifc.fetch_row, 0);
    chk("restart_col", ifc.fetch_col, 0);
    finish_frame(1'b0);
    check_frame();

    // timeout instance: patchifier stuck PROCESSING after launch
    ifc2.start = 1'b1;
    step();
    ifc2.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ifc2.pf_en) begin ok = 1'b1; break; end
      step();
    end
    chk("to_launch", ok, 1);
    step();
    ifc2.pf_state = 2'b01;
    seen_done = 1'b0;
    for (int k = 1; k < 20; k++) begin
      step();
      if (ifc2.frame_done) seen_done = 1'b1;
    end
    chk("to_busy_before", ifc2.busy, 1);
    chk("to_err_before", ifc2.error, 0);
    step();
    chk("to_idle", ifc2.busy, 0);
    chk("to_err", ifc2.error, 1);
    if (ifc2.frame_done) seen_done = 1'b1;
    step();
    if (ifc2.frame_done) seen_done = 1'b1;
    chk("to_no_done", seen_done, 0);
    chk("to_err_sticky", ifc2.error, 1);
    ifc2.pf_state = 2'b00;
    ifc2.start = 1'b1;
    step();
    ifc2.start = 1'b0;
    chk("to_err_cleared", ifc2.error, 0);
    chk("to_restart_busy", ifc2.busy, 1);
    ifc2.abort = 1'b1;
    step();
    ifc2.abort = 1'b0;
    chk("to_abort_idle", ifc2.busy, 0);

    mon_en = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
